matrix_scan_controller: RTL and testbench

//  Sequences one HUB75-style LED matrix panel: fetches pixel bits from the framebuffer, shifts them out
//  on a divided shift clock, latches them, drives row address and output-enable with binary-coded

---
 rtl/matrix_scan_controller.sv | 168 ++++++++++++++++
 tb/tb_matrix_scan_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_controller.sv
// HUB75 panel scan sequencer: fetch, shift, latch and BCM display over BITPLANES planes per row.
// Optional `define SCAN_BRIGHTNESS_EN adds a 3-bit brightness input that trims each display window.
module matrix_scan_controller #(
    parameter int PIXELS_PER_ROW = 32,
    parameter int ROW_ADDR_WIDTH = 4,
    parameter int BITPLANES      = 4,
    parameter int SCLK_DIV       = 2,
    parameter int OE_BASE        = 8
) (
    input  logic                                              clk_in,
    input  logic                                              reset,
    input  logic                                              enable,
    output logic [ROW_ADDR_WIDTH+$clog2(PIXELS_PER_ROW)-1:0]  fb_addr,
    output logic [((BITPLANES > 1) ? $clog2(BITPLANES) : 1)-1:0] fb_plane,
    input  logic [5:0]                                        fb_data,
`ifdef SCAN_BRIGHTNESS_EN
    input  logic [2:0]                                        brightness,
`endif
    output logic [5:0]                                        rgb,
    output logic                                              sclk,
    output logic                                              latch,
    output logic                                              oe_n,
    output logic [ROW_ADDR_WIDTH-1:0]                         row_sel,
    output logic                                              frame_done
);

    localparam int COL_W = $clog2(PIXELS_PER_ROW);
    localparam int PL_W  = (BITPLANES > 1) ? $clog2(BITPLANES) : 1;
    localparam int PH_W  = $clog2(2 * SCLK_DIV);
    localparam int WIN_W = $clog2(OE_BASE << (BITPLANES - 1)) + 1;
    localparam int SC_W  = WIN_W + 3;

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HIGH    = PH_W'(SCLK_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(PIXELS_PER_ROW - 1);
    localparam logic [COL_W-1:0] COL_PENULT = COL_W'(PIXELS_PER_ROW - 2);
    localparam logic [PL_W-1:0]  PLANE_LAST = PL_W'(BITPLANES - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    state_t                    state;
    logic [COL_W-1:0]          col;
    logic [PH_W-1:0]           phase;
    logic [ROW_ADDR_WIDTH-1:0] shift_row;
    logic [ROW_ADDR_WIDTH-1:0] next_row;
    logic [PL_W-1:0]           plane;
    logic [PL_W-1:0]           next_plane;
    logic [WIN_W-1:0]          win_cnt;
    logic [WIN_W-1:0]          win_len;
    logic [SC_W-1:0]           on_len;
    logic [SC_W-1:0]           on_len_calc;
    logic                      primed;
    logic                      last_plane;
    logic                      last_row;

    assign last_plane = (plane == PLANE_LAST);
    assign last_row   = (shift_row == '1);
    assign next_plane = last_plane ? '0 : plane + PL_W'(1);
    assign next_row   = last_plane ? shift_row + ROW_ADDR_WIDTH'(1) : shift_row;
    assign win_len    = WIN_W'(OE_BASE) << plane;

`ifdef SCAN_BRIGHTNESS_EN
    logic [SC_W-1:0] scaled;
    assign scaled      = (SC_W'(win_len) * SC_W'({1'b0, brightness} + 4'd1)) >> 3;
    assign on_len_calc = (scaled == '0) ? SC_W'(1) : scaled;
`else
    assign on_len_calc = SC_W'(win_len);
`endif

    // The framebuffer answers one cycle after the address, so the address always runs one
    // column ahead of rgb; the next plane's column 0 is prefetched during the last column.
    // primed guarantees IDLE has held address 0 long enough for column 0 data to be valid.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rgb        <= '0;
            sclk       <= 1'b0;
            latch      <= 1'b0;
            oe_n       <= 1'b1;
            row_sel    <= '0;
            fb_addr    <= '0;
            fb_plane   <= '0;
            frame_done <= 1'b0;
            col        <= '0;
            phase      <= '0;
            shift_row  <= '0;
            plane      <= '0;
            win_cnt    <= '0;
            on_len     <= '0;
            primed     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    primed <= 1'b1;
                    if (enable && primed) begin
                        state   <= SHIFT;
                        rgb     <= fb_data;
                        col     <= '0;
                        phase   <= '0;
                        sclk    <= 1'b0;
                        fb_addr <= {shift_row, COL_W'(1)};
                    end
                end
                SHIFT: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        sclk  <= 1'b0;
                        if (col == COL_LAST) begin
                            state <= BLANK;
                        end else begin
                            col <= col + COL_W'(1);
                            rgb <= fb_data;
                            if (col == COL_PENULT) begin
                                fb_addr  <= {next_row, COL_W'(0)};
                                fb_plane <= next_plane;
                            end else begin
                                fb_addr <= {shift_row, col + COL_W'(2)};
                            end
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                        sclk  <= (phase >= PH_HIGH);
                    end
                end
                BLANK: begin
                    state   <= LATCH;
                    latch   <= 1'b1;
                    row_sel <= shift_row;
                end
                LATCH: begin
                    state   <= DISPLAY;
                    latch   <= 1'b0;
                    oe_n    <= 1'b0;
                    win_cnt <= '0;
                    on_len  <= on_len_calc;
                end
                DISPLAY: begin
                    if (win_cnt == win_len - WIN_W'(1)) begin
                        oe_n       <= 1'b1;
                        frame_done <= last_plane && last_row;
                        if (enable) begin
                            state     <= SHIFT;
                            shift_row <= next_row;
                            plane     <= next_plane;
                            rgb       <= fb_data;
                            col       <= '0;
                            phase     <= '0;
                            fb_addr   <= {next_row, COL_W'(1)};
                        end else begin
                            state     <= IDLE;
                            shift_row <= '0;
                            plane     <= '0;
                            fb_addr   <= '0;
                            fb_plane  <= '0;
                            primed    <= 1'b0;
                        end
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        oe_n    <= !((SC_W'(win_cnt) + SC_W'(1)) < on_len);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller with a one-cycle-latency framebuffer model.
// Build with +define+SCAN_BRIGHTNESS_EN to also exercise the brightness trim.
module tb_matrix_scan_controller;

    localparam int PIXELS  = 32;
    localparam int ROW_W   = 4;
    localparam int PLANES  = 4;
    localparam int DIV     = 2;
    localparam int OE_BASE = 8;
    localparam int COL_W   = $clog2(PIXELS);
    localparam int ADDR_W  = ROW_W + COL_W;
    localparam int ROWS    = 1 << ROW_W;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              enable;
    logic [ADDR_W-1:0] fb_addr;
    logic [1:0]        fb_plane;
    logic [5:0]        fb_data = '0;
    logic [5:0]        rgb;
    logic              sclk;
    logic              latch;
    logic              oe_n;
    logic [ROW_W-1:0]  row_sel;
    logic              frame_done;
`ifdef SCAN_BRIGHTNESS_EN
    logic [2:0]        brightness = 3'd7;
`endif

    int checks = 0;
    int errors = 0;

    int cyc = 0, sclk_cnt = 0, low_cnt = 0, last_rise = 0, last_latch = 0, last_latch_plane = 0;
    int planes_done = 0, fd_count = 0, latch_events = 0, mdl_row = 0, mdl_plane = 0;
    int last_low [PLANES];
    bit latch_valid = 1'b0, mon_en = 1'b1;
    logic prev_sclk = 1'b0, prev_latch = 1'b0, prev_oe = 1'b1;
    int pd, le;

    matrix_scan_controller #(
        .PIXELS_PER_ROW(PIXELS), .ROW_ADDR_WIDTH(ROW_W), .BITPLANES(PLANES),
        .SCLK_DIV(DIV), .OE_BASE(OE_BASE)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .fb_addr    (fb_addr),
        .fb_plane   (fb_plane),
        .fb_data    (fb_data),
`ifdef SCAN_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .rgb        (rgb),
        .sclk       (sclk),
        .latch      (latch),
        .oe_n       (oe_n),
        .row_sel    (row_sel),
        .frame_done (frame_done)
    );

    initial forever #5 clk_in = ~clk_in;

    function automatic logic [5:0] pixel(input int c, input int r, input int p);
        return 6'((c + 2 * r + 5 * p) & 63);
    endfunction

    function automatic int onLen(input int p);
        int w = OE_BASE << p;
`ifdef SCAN_BRIGHTNESS_EN
        int s = (w * (int'(brightness) + 1)) >> 3;
        return (s < 1) ? 1 : s;
`else
        return w;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input int cycles);
        enable = en;
        repeat (cycles) @(negedge clk_in);
    endtask

    // Framebuffer with one cycle of read latency.
    always @(posedge clk_in)
        fb_data <= pixel(int'(fb_addr[COL_W-1:0]), int'(fb_addr[ADDR_W-1:COL_W]), int'(fb_plane));

    // Panel-side observer: tracks which row/plane should be on the wire and checks every event.
    always @(negedge clk_in) begin
        cyc++;
        if (!mon_en || reset) begin
            sclk_cnt = 0;
            low_cnt = 0;
            latch_valid = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                checkOutput("rgbAtRise", rgb, pixel(sclk_cnt, mdl_row, mdl_plane));
                if (sclk_cnt > 0) checkOutput("sclkPeriod", cyc - last_rise, 2 * DIV);
                last_rise = cyc;
                sclk_cnt++;
            end
            if (latch) begin
                checkOutput("latchSclk", sclk, 0);
                checkOutput("latchOe", oe_n, 1);
                checkOutput("latchWidth", prev_latch, 0);
                checkOutput("latchRow", row_sel, mdl_row);
                checkOutput("sclkCount", sclk_cnt, PIXELS);
                if (latch_valid)
                    checkOutput("planePeriod", cyc - last_latch, 2 * DIV * PIXELS + 2 + (OE_BASE << last_latch_plane));
                last_latch = cyc;
                last_latch_plane = mdl_plane;
                latch_valid = 1'b1;
                sclk_cnt = 0;
                latch_events++;
            end
            if (!oe_n) low_cnt++;
            if (oe_n && !prev_oe) begin
                checkOutput("oeLow", low_cnt, onLen(mdl_plane));
                last_low[mdl_plane] = low_cnt;
                low_cnt = 0;
                planes_done++;
                if (mdl_plane == PLANES - 1) begin
                    mdl_plane = 0;
                    mdl_row = (mdl_row + 1) % ROWS;
                end else begin
                    mdl_plane++;
                end
            end
            if (frame_done) begin
                fd_count++;
                checkOutput("frameDoneRow", row_sel, ROWS - 1);
                checkOutput("frameDonePlane", last_latch_plane, PLANES - 1);
            end
        end
        prev_sclk = sclk;
        prev_latch = latch;
        prev_oe = oe_n;
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        #12;
        checkOutput("resetOe", oe_n, 1);
        checkOutput("resetSclk", sclk, 0);
        checkOutput("resetLatch", latch, 0);
        checkOutput("resetRowSel", row_sel, 0);
        checkOutput("resetAddr", fb_addr, 0);
        checkOutput("resetPlane", fb_plane, 0);
        checkOutput("resetRgb", rgb, 0);
        checkOutput("resetFrameDone", frame_done, 0);
        @(negedge clk_in);
        reset = 1'b0;
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 0);

        // Full frame: every row and plane, then the row address wraps back to 0.
        for (int i = 0; i < 12000 && fd_count < 1; i++) @(negedge clk_in);
        checkOutput("frameDoneSeen", fd_count, 1);
        checkOutput("framePlanes", planes_done, ROWS * PLANES);
        le = latch_events;
        for (int i = 0; i < 300 && latch_events == le; i++) @(negedge clk_in);
        checkOutput("rowWrap", row_sel, 0);

        // Drop enable while shifting row 3 plane 1 of the second frame.
        for (int i = 0; i < 4000 && !(mdl_row == 3 && mdl_plane == 1 && sclk_cnt >= 5 && sclk_cnt < 20); i++)
            @(negedge clk_in);
        checkOutput("reachRow3Plane1", (mdl_row == 3 && mdl_plane == 1), 1);
        pd = planes_done;
        applyStimulus(1'b0, 0);
        for (int i = 0; i < 500 && planes_done == pd; i++) @(negedge clk_in);
        checkOutput("dropPlaneDone", planes_done, pd + 1);
        repeat (3) @(negedge clk_in);
        le = latch_events;
        repeat (40) @(negedge clk_in);
        checkOutput("dropRowSel", row_sel, 3);
        checkOutput("dropOe", oe_n, 1);
        checkOutput("dropSclk", sclk, 0);
        checkOutput("dropAddr", fb_addr, 0);
        checkOutput("dropPlane", fb_plane, 0);
        checkOutput("dropNoLatch", latch_events, le);
        checkOutput("dropFrameDone", fd_count, 1);
        mdl_row = 0;
        mdl_plane = 0;
        latch_valid = 1'b0;

        // Restart from row 0, then reset asynchronously in the middle of row 2's display window.
        applyStimulus(1'b1, 0);
        for (int i = 0; i < 3000 && !(mdl_row == 2 && oe_n == 1'b0); i++) @(negedge clk_in);
        checkOutput("reachRow2Display", oe_n, 0);
        checkOutput("preResetRowSel", row_sel, 2);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncOe", oe_n, 1);
        checkOutput("asyncSclk", sclk, 0);
        checkOutput("asyncLatch", latch, 0);
        checkOutput("asyncRowSel", row_sel, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (5) @(negedge clk_in);
        checkOutput("idleOe", oe_n, 1);
        checkOutput("idleSclk", sclk, 0);
        checkOutput("idleLatch", latch, 0);
        checkOutput("idleAddr", fb_addr, 0);
        checkOutput("idleRgb", rgb, 0);
        mdl_row = 0;
        mdl_plane = 0;
        mon_en = 1'b1;

`ifdef SCAN_BRIGHTNESS_EN
        brightness = 3'd0;
        applyStimulus(1'b1, 0);
        pd = planes_done;
        for (int i = 0; i < 2000 && planes_done < pd + PLANES; i++) @(negedge clk_in);
        checkOutput("bright0Plane0", last_low[0], 1);
        checkOutput("bright0Plane3", last_low[3], 8);
        brightness = 3'd3;
        pd = planes_done;
        for (int i = 0; i < 2000 && planes_done < pd + PLANES; i++) @(negedge clk_in);
        checkOutput("bright3Plane0", last_low[0], 4);
        checkOutput("bright3Plane3", last_low[3], 32);
        applyStimulus(1'b0, 200);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
